spie_arb: RTL and testbench

//  Shares one spie SPI device between NREQ bus requesters (e.g. CPU port, SD block engine).

---
 rtl/spie_arb_pkg.sv | 13 +
 rtl/spie_arb_rr.sv | 23 ++
 rtl/spie_arb.sv | 136 +++++++++++++
 tb/tb_spie_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spie_arb_pkg.sv
// Shared definitions for the spie arbiter: ctrl register field positions,
// register addresses and arbiter state encodings.
package spie_arb_pkg;
  localparam int   CTRL_CS_LSB = 0;
  localparam int   CTRL_CS_MSB = 2;
  localparam logic ADDR_CTRL   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/spie_arb_rr.sv
// Combinational round-robin picker: the first set request after last_i
// (wrapping) wins.
module spie_arb_rr #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic            any_o,
  output logic [IDXW-1:0] win_o
);
  // Scan from farthest to nearest so the nearest candidate overrides.
  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[IDXW'((int'(last_i) + k) % NREQ)]) begin
        any_o = 1'b1;
        win_o = IDXW'((int'(last_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/spie_arb.sv
// Arbiter sharing one spie SPI slave port between NREQ requesters, with
// chip-select locking and an idle watchdog that force-releases a stale lock.
module spie_arb
  import spie_arb_pkg::*;
#(
  parameter int          NREQ         = 2,
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int          TW           = 21,
  parameter logic [31:0] REL_CTRL     = 32'h0,
  localparam int         IDXW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_stb,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0] req_data_in,
  output logic [31:0]        req_data_out,
  output logic [NREQ-1:0]    req_ack,
  output logic               spi_stb,
  output logic               spi_we,
  output logic               spi_addr,
  output logic [31:0]        spi_data_in,
  input  logic [31:0]        spi_data_out,
  input  logic               spi_ack,
  output logic [IDXW-1:0]    owner,
  output logic               locked,
  output logic               rel_evt
);
  localparam logic [TW-1:0]   WD_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam bit              WD_EN    = (LOCK_TIMEOUT != 0);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic            locked_q, locked_d;
  logic [IDXW-1:0] owner_q, owner_d, last_q, last_d, win_q, win_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] elig;
  logic            rr_any, issue;
  logic [IDXW-1:0] rr_win;
  logic [31:0]     win_data;
  logic            unused_spi_ack;

  // spie acks combinationally with stb, so sequencing ignores spi_ack.
  assign unused_spi_ack = spi_ack;

  assign elig     = locked_q ? (req_stb & (NREQ'(1) << owner_q)) : req_stb;
  assign win_data = req_data_in[32*win_q +: 32];
  assign issue    = (state_q == ST_ISSUE) && req_stb[win_q];
  assign owner    = owner_q;
  assign locked   = locked_q;

  spie_arb_rr #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req_i  (elig),
    .last_i (last_q),
    .any_o  (rr_any),
    .win_o  (rr_win)
  );

  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    last_d       = last_q;
    win_d        = win_q;
    wdog_d       = locked_q ? wdog_q : '0;
    req_ack      = '0;
    req_data_out = '0;
    spi_stb      = 1'b0;
    spi_we       = 1'b0;
    spi_addr     = 1'b0;
    spi_data_in  = '0;
    rel_evt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          win_d   = rr_win;
          last_d  = rr_win;
          state_d = ST_ISSUE;
        end else if (locked_q) begin
          if (WD_EN && wdog_q == WD_LAST) state_d = ST_FORCE;
          else if (wdog_q != '1)          wdog_d  = wdog_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        // A requester that dropped its strobe cancels silently.
        state_d = ST_IDLE;
        if (issue) begin
          spi_stb        = 1'b1;
          spi_we         = req_we[win_q];
          spi_addr       = req_addr[win_q];
          spi_data_in    = win_data;
          req_ack[win_q] = 1'b1;
          req_data_out   = spi_data_out;
          wdog_d         = '0;
          if (spi_we && spi_addr == ADDR_CTRL) begin
            if (|win_data[CTRL_CS_MSB:CTRL_CS_LSB]) begin
              locked_d = 1'b1;
              owner_d  = win_q;
            end else begin
              locked_d = 1'b0;
            end
          end
        end
      end
      ST_FORCE: begin
        spi_stb     = 1'b1;
        spi_we      = 1'b1;
        spi_addr    = ADDR_CTRL;
        spi_data_in = REL_CTRL;
        rel_evt     = 1'b1;
        locked_d    = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      win_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      win_q    <= win_d;
      wdog_q   <= wdog_d;
    end
  end
endmodule

// File: tb/tb_spie_arb.sv
// Bench for spie_arb: directed vector table, hand-written lock/watchdog/reset
// sequences, then random traffic against a transaction-level model.
module tb_spie_arb;
  localparam logic [31:0] REL  = 32'h0000_0F00;
  localparam logic [31:0] STAT = 32'h8000_00A1;
  localparam logic [31:0] DREG = 32'h0000_0057;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_stb, req_we, req_addr, req_ack;
  logic [63:0] req_data_in;
  logic [31:0] req_data_out, spi_data_in, spi_data_out;
  logic        spi_stb, spi_we, spi_addr, spi_ack, locked, rel_evt;
  logic [0:0]  owner;
  logic [71:0] obs;

  int n_pass = 0;
  int n_tot  = 0;

  spie_arb #(.NREQ(2), .LOCK_TIMEOUT(TO), .TW(21), .REL_CTRL(REL)) dut (
    .clk(clk), .rst(rst), .req_stb(req_stb), .req_we(req_we), .req_addr(req_addr),
    .req_data_in(req_data_in), .req_data_out(req_data_out), .req_ack(req_ack),
    .spi_stb(spi_stb), .spi_we(spi_we), .spi_addr(spi_addr), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_ack(spi_ack), .owner(owner), .locked(locked),
    .rel_evt(rel_evt)
  );

  always #5 clk = ~clk;

  // Minimal spie slave: fixed status/data read values, ack follows stb.
  assign spi_data_out = spi_stb ? (spi_addr ? STAT : DREG) : 32'h0;
  assign spi_ack      = spi_stb;
  assign obs = {req_ack, spi_stb, spi_we, spi_addr, spi_data_in, req_data_out, locked, owner, rel_evt};

  function automatic logic [71:0] pk(logic [1:0] a, logic s, logic w, logic ad, logic [31:0] di,
                                     logic [31:0] dout, logic lk, logic ow, logic rel);
    return {a, s, w, ad, di, dout, lk, ow, rel};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [1:0] s, w, a, input logic [31:0] d0, d1);
    @(posedge clk); #1;
    req_stb = s; req_we = w; req_addr = a; req_data_in = {d1, d0};
    @(negedge clk);
  endtask

  // Reference model: pending grant (-1 none), pending forced release, lock, RR pointer, idle count.
  int m_pend, m_last, m_owner, m_idle;
  bit m_force, m_locked;

  task automatic model_reset();
    m_pend = -1; m_last = 1; m_owner = 0; m_idle = 0; m_force = 0; m_locked = 0;
  endtask

  task automatic model_out(output logic [71:0] e);
    logic [1:0] a = 2'b00;
    logic s = 0, w = 0, ad = 0, rel = 0;
    logic [31:0] di = 0, dout = 0;
    if (m_pend >= 0 && req_stb[m_pend]) begin
      a[m_pend] = 1'b1; s = 1; w = req_we[m_pend]; ad = req_addr[m_pend];
      di = req_data_in[32*m_pend +: 32];
      dout = ad ? STAT : DREG;
    end else if (m_force) begin
      s = 1; w = 1; ad = 1; di = REL; rel = 1;
    end
    e = pk(a, s, w, ad, di, dout, m_locked, m_owner[0], rel);
  endtask

  task automatic model_next();
    bit lk0 = m_locked;
    int w = -1;
    if (m_pend >= 0) begin
      if (req_stb[m_pend]) begin
        if (req_we[m_pend] && req_addr[m_pend]) begin
          if (req_data_in[32*m_pend +: 3] != 3'd0) begin m_locked = 1; m_owner = m_pend; end
          else m_locked = 0;
        end
        m_idle = 0;
      end
      m_pend = -1;
    end else if (m_force) begin
      m_locked = 0; m_force = 0;
    end else begin
      for (int j = 1; j <= 2; j++) begin
        int c = (m_last + j) % 2;
        if (w < 0 && req_stb[c] && (!lk0 || c == m_owner)) w = c;
      end
      if (w >= 0) begin m_pend = w; m_last = w; end
      else if (lk0 && m_idle == TO - 1) m_force = 1;
      else if (lk0) m_idle++;
    end
    if (!lk0) m_idle = 0;
  endtask

  typedef struct packed {
    logic [1:0]  stb, we, addr;
    logic [31:0] d0, d1;
    logic [71:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    int first_rel, first_ack, ack_k;
    logic early;
    logic [36:0] bus_at_rel;
    logic [1:0] prev_ack;
    logic [71:0] e;

    // Arbitration, status read, lock/unlock sequence (one row per cycle).
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b01,1,0,0,32'h0,DREG,0,0,0)};
    tbl[2]  = '{2'b10, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[3]  = '{2'b10, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b10,1,0,0,32'h0,DREG,0,0,0)};
    tbl[4]  = '{2'b01, 2'b00, 2'b01, 32'h0, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[5]  = '{2'b01, 2'b00, 2'b01, 32'h0, 32'h0,  pk(2'b01,1,0,1,32'h0,STAT,0,0,0)};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[7]  = '{2'b01, 2'b01, 2'b01, 32'h1, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[8]  = '{2'b11, 2'b11, 2'b01, 32'h1, 32'h33, pk(2'b01,1,1,1,32'h1,STAT,0,0,0)};
    tbl[9]  = '{2'b11, 2'b11, 2'b00, 32'hA5, 32'h33, pk(2'b00,0,0,0,32'h0,32'h0,1,0,0)};
    tbl[10] = '{2'b11, 2'b11, 2'b00, 32'hA5, 32'h33, pk(2'b01,1,1,0,32'hA5,DREG,1,0,0)};
    tbl[11] = '{2'b11, 2'b11, 2'b01, 32'h0, 32'h33, pk(2'b00,0,0,0,32'h0,32'h0,1,0,0)};
    tbl[12] = '{2'b11, 2'b11, 2'b01, 32'h0, 32'h33, pk(2'b01,1,1,1,32'h0,STAT,1,0,0)};
    tbl[13] = '{2'b10, 2'b10, 2'b00, 32'h0, 32'h33, pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};
    tbl[14] = '{2'b10, 2'b10, 2'b00, 32'h0, 32'h33, pk(2'b10,1,1,0,32'h33,DREG,0,0,0)};
    tbl[15] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0,  pk(2'b00,0,0,0,32'h0,32'h0,0,0,0)};

    rst = 1; req_stb = 0; req_we = 0; req_addr = 0; req_data_in = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", obs, 72'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stb, tbl[i].we, tbl[i].addr, tbl[i].d0, tbl[i].d1);
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Watchdog expiry with a stalled non-owner.
    drive(2'b01, 2'b01, 2'b01, 32'h2, 32'h0);
    drive(2'b01, 2'b01, 2'b01, 32'h2, 32'h0);
    chk("t4_lock_ack", {70'h0, req_ack}, {70'h0, 2'b01});
    first_rel = 0; first_ack = 0; early = 0; bus_at_rel = '0;
    for (int k = 1; k <= 40 && first_ack == 0; k++) begin
      drive(2'b10, 2'b10, 2'b00, 32'h0, 32'h77);
      if (rel_evt && first_rel == 0) begin
        first_rel = k;
        bus_at_rel = {req_ack, spi_stb, spi_we, spi_addr, spi_data_in};
      end
      if (req_ack != 2'b00) begin
        if (first_rel == 0) early = 1;
        if (req_ack[1]) first_ack = k;
      end
    end
    chk("t4_rel_cycle", 72'(first_rel), 72'(17));
    chk("t4_force_bus", 72'(bus_at_rel), 72'({2'b00, 1'b1, 1'b1, 1'b1, REL}));
    chk("t4_ack1_cycle", 72'(first_ack), 72'(19));
    chk("t4_no_early_ack", 72'(early), 72'(0));
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("t4_unlocked", 72'(locked), 72'(0));

    // Owner strobe in the expiry cycle wins and restarts the watchdog.
    drive(2'b01, 2'b01, 2'b01, 32'h4, 32'h0);
    drive(2'b01, 2'b01, 2'b01, 32'h4, 32'h0);
    first_rel = 0; ack_k = 0;
    for (int k = 1; k <= 60 && first_rel == 0; k++) begin
      drive((k == 16 || k == 17) ? 2'b01 : 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      if (req_ack[0] && ack_k == 0) ack_k = k;
      if (rel_evt) first_rel = k;
    end
    chk("t5_owner_ack_cycle", 72'(ack_k), 72'(17));
    chk("t5_rel_cycle", 72'(first_rel), 72'(34));

    // Reset in the middle of an ISSUE, then a cancelled access.
    drive(2'b01, 2'b01, 2'b01, 32'h1, 32'h0);
    drive(2'b01, 2'b01, 2'b01, 32'h1, 32'h0);
    drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
    @(posedge clk); #2 rst = 1;
    @(negedge clk);
    chk("t6_rst_outputs", obs, 72'h0);
    @(posedge clk); #1;
    rst = 0; req_stb = 2'b10; req_we = 2'b10; req_addr = 2'b00; req_data_in = {32'h99, 32'h0};
    @(negedge clk);
    chk("t6_lock_clear", {70'h0, req_ack, locked}, 72'h0);
    drive(2'b10, 2'b10, 2'b00, 32'h0, 32'h99);
    chk("t6_req1_served", {req_ack, spi_stb, spi_we, spi_data_in}, {2'b10, 1'b1, 1'b1, 32'h99});
    drive(2'b01, 2'b00, 2'b01, 32'h0, 32'h0);
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("t6_cancel", {69'h0, req_ack, spi_stb}, 72'h0);
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("t6_post_cancel", {70'h0, req_ack}, {70'h0, 2'b10});

    // Random traffic against the model.
    @(posedge clk); #1 rst = 1; req_stb = 0;
    @(posedge clk); #1 rst = 0;
    model_reset();
    prev_ack = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        bit quiet = ((cyc / 150) % 4) == 3;
        bit start = 0;
        if (req_stb[i] && prev_ack[i]) begin
          req_stb[i] = 0;
          start = !quiet && ($urandom_range(0, 1) == 0);
        end else if (req_stb[i] && $urandom_range(0, 19) == 0) begin
          req_stb[i] = 0;
        end else if (!req_stb[i]) begin
          start = !quiet && ($urandom_range(0, 2) == 0);
        end
        if (start) begin
          logic [31:0] d = $urandom;
          req_stb[i] = 1; req_we[i] = 1'($urandom); req_addr[i] = 1'($urandom);
          if (req_we[i] && req_addr[i])
            d[2:0] = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(1, 7));
          req_data_in[32*i +: 32] = d;
        end
      end
      @(negedge clk);
      model_out(e);
      chk("rnd", obs, e);
      prev_ack = req_ack;
      model_next();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
